// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin arbiter: shares one AXI-Stream sink between NUM_PORTS sources.
// A grant is held from the first beat of a packet until its tlast beat is accepted.
module axis_rr_arbiter #(
    parameter int NUM_PORTS   = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int TID_WIDTH   = 8,
    parameter int TDEST_WIDTH = 4,
    parameter int TUSER_WIDTH = 4,
    localparam int SEL_W      = $clog2(NUM_PORTS),
    localparam int KW         = DATA_WIDTH / 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_PORTS-1:0]             s_axis_tvalid,
    output logic [NUM_PORTS-1:0]             s_axis_tready,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic [NUM_PORTS*KW-1:0]          s_axis_tstrb,
    input  logic [NUM_PORTS*KW-1:0]          s_axis_tkeep,
    input  logic [NUM_PORTS-1:0]             s_axis_tlast,
    input  logic [NUM_PORTS*TID_WIDTH-1:0]   s_axis_tid,
    input  logic [NUM_PORTS*TDEST_WIDTH-1:0] s_axis_tdest,
    input  logic [NUM_PORTS*TUSER_WIDTH-1:0] s_axis_tuser,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic [KW-1:0]                    m_axis_tstrb,
    output logic [KW-1:0]                    m_axis_tkeep,
    output logic                             m_axis_tlast,
    output logic [TID_WIDTH-1:0]             m_axis_tid,
    output logic [TDEST_WIDTH-1:0]           m_axis_tdest,
    output logic [TUSER_WIDTH-1:0]           m_axis_tuser,
    output logic [SEL_W-1:0]                 grant_idx,
    output logic                             busy
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] grant_q, grant_d;
    logic [SEL_W-1:0] last_grant_q, last_grant_d;
    logic [SEL_W-1:0] winner;
    logic             found;
    logic [SEL_W:0]   cand;
    logic             sel_valid;
    logic             sel_last;

    // Search starts just after the last owner; the wrap uses a compare so a
    // non-power-of-2 port count can never select an index past NUM_PORTS-1.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int off = 1; off <= NUM_PORTS; off++) begin
            cand = {1'b0, last_grant_q} + (SEL_W+1)'(off);
            if (cand >= (SEL_W+1)'(NUM_PORTS)) begin
                cand = cand - (SEL_W+1)'(NUM_PORTS);
            end
            if (!found && s_axis_tvalid[cand[SEL_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[SEL_W-1:0];
            end
        end
    end

    always_comb begin
        sel_valid     = 1'b0;
        sel_last      = 1'b0;
        s_axis_tready = '0;
        m_axis_tdata  = '0;
        m_axis_tstrb  = '0;
        m_axis_tkeep  = '0;
        m_axis_tid    = '0;
        m_axis_tdest  = '0;
        m_axis_tuser  = '0;
        if (state_q == LOCKED) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (grant_q == SEL_W'(i)) begin
                    sel_valid        = s_axis_tvalid[i];
                    sel_last         = s_axis_tlast[i];
                    s_axis_tready[i] = m_axis_tready;
                    m_axis_tdata     = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                    m_axis_tstrb     = s_axis_tstrb[i*KW +: KW];
                    m_axis_tkeep     = s_axis_tkeep[i*KW +: KW];
                    m_axis_tid       = s_axis_tid[i*TID_WIDTH +: TID_WIDTH];
                    m_axis_tdest     = s_axis_tdest[i*TDEST_WIDTH +: TDEST_WIDTH];
                    m_axis_tuser     = s_axis_tuser[i*TUSER_WIDTH +: TUSER_WIDTH];
                end
            end
        end
        m_axis_tvalid = sel_valid;
        m_axis_tlast  = sel_last;
    end

    // IDLE arbitrates (one bubble per packet); LOCKED holds until tlast is accepted.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = winner;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (sel_valid && m_axis_tready && sel_last) begin
                    state_d      = IDLE;
                    last_grant_d = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= SEL_W'(NUM_PORTS-1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign grant_idx = grant_q;
    assign busy      = (state_q == LOCKED);

endmodule

// File: doc/axis_rr_arbiter.md
Name: axis_rr_arbiter

Overview:
- Packet-level round-robin arbiter that shares one AXI-Stream sink, normally the team's AXIS FIFO, between NUM_PORTS AXI-Stream sources.
- A grant is held from the first beat of a packet until the beat with tlast is accepted, so packets are never interleaved.
- Sits between the requester blocks and the FIFO slave port.
- Exposes the current grant for debug and for the scheduler.

Parameters:
- NUM_PORTS, 4, number of slave (requester) ports; must be ≥2.
- DATA_WIDTH, 32, tdata width; must be a multiple of 8.
- TID_WIDTH, 8, tid width.
- TDEST_WIDTH, 4, tdest width.
- TUSER_WIDTH, 4, tuser width.
- Derived: SEL_W = $clog2(NUM_PORTS); KW = DATA_WIDTH/8.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- s_axis_tvalid  in  NUM_PORTS  per-port tvalid; bit i = port i.
- s_axis_tready  out  NUM_PORTS  per-port tready.
- s_axis_tdata  in  NUM_PORTS*DATA_WIDTH  packed; port i at [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tstrb  in  NUM_PORTS*KW  packed the same way.
- s_axis_tkeep  in  NUM_PORTS*KW  packed the same way.
- s_axis_tlast  in  NUM_PORTS  per-port tlast.
- s_axis_tid  in  NUM_PORTS*TID_WIDTH  packed.
- s_axis_tdest  in  NUM_PORTS*TDEST_WIDTH  packed.
- s_axis_tuser  in  NUM_PORTS*TUSER_WIDTH  packed.
- m_axis_tvalid  out  1  to sink.
- m_axis_tready  in  1  from sink.
- m_axis_tdata  out  DATA_WIDTH.
- m_axis_tstrb  out  KW.
- m_axis_tkeep  out  KW.
- m_axis_tlast  out  1.
- m_axis_tid  out  TID_WIDTH.
- m_axis_tdest  out  TDEST_WIDTH.
- m_axis_tuser  out  TUSER_WIDTH.
- grant_idx  out  SEL_W  index of the port currently owning the sink.
- busy  out  1  high while a packet is in progress (state LOCKED).

Behaviour:
- State machine: IDLE, LOCKED. Registers: state, grant (SEL_W), last_grant (SEL_W).
- Reset, asynchronous, values held while rst_n is low:
  - state = IDLE, grant = 0, last_grant = NUM_PORTS-1, so port 0 has first priority.
  - Outputs: m_axis_tvalid = 0, s_axis_tready = all 0, busy = 0, grant_idx = 0, all m_axis_* payload = 0.
- IDLE:
  - s_axis_tready = 0 and m_axis_tvalid = 0; payload outputs are driven to 0.
  - If any s_axis_tvalid bit is set, pick the first set bit searching last_grant+1, last_grant+2, ... modulo NUM_PORTS.
  - On that clock edge: grant <= winner, state <= LOCKED.
  - If no request is pending, stay in IDLE.
  - Arbitration latency: 1 cycle from a request in IDLE to m_axis_tvalid.
- LOCKED:
  - Combinational pass-through, no added latency:
    - m_axis_tvalid = s_axis_tvalid[grant].
    - All m_axis_* payload = slice[grant].
    - s_axis_tready[i] = (i == grant) & m_axis_tready.
    - All other tready bits are 0.
  - On a handshake (s_axis_tvalid[grant] & m_axis_tready) with s_axis_tlast[grant] = 1:
    - state <= IDLE, last_grant <= grant.
  - Handshakes with tlast = 0 keep the lock.
- One-cycle bubble in IDLE between consecutive packets. This is decided behaviour: maximum throughput is N beats per N+1 cycles for N-beat packets.
- Rotation: after port k finishes, priority order is k+1 … NUM_PORTS-1, 0 … k. A single active requester is re-granted after the bubble.
- No pre-emption:
  - Deasserting s_axis_tvalid[grant] mid-packet keeps the lock and stalls the sink (m_axis_tvalid = 0).
  - Requests from other ports are ignored until tlast.
- Sink backpressure (m_axis_tready = 0) is passed only to the granted port. Payload stays stable because the source must hold it per AXIS rules.
- Signal mapping: grant_idx = grant register; busy = (state == LOCKED).
- Reset mid-packet:
  - Immediate return to IDLE with the reset values; the packet is truncated and no tlast is emitted.
  - After reset is released, the earliest tready is one cycle after the first request is sampled.
- Source tvalid depending on tready is not supported; sources must follow AXIS.
- Grants to an index ≥ NUM_PORTS are impossible. For non-power-of-2 NUM_PORTS the wrap is done by compare, not by truncation.

Test Plan:
- Reset release with all s_axis_tvalid = 1 and m_axis_tready = 1:
  - Cycle 0 after release: all tready = 0, m_axis_tvalid = 0.
  - Next cycle: grant_idx = 0, busy = 1, port 0 beats appear on the master with tready = 4'b0001.
- Ports 0–3 each send a 3-beat packet, tdata = {port, beat}, with all ports requesting continuously:
  - Output order is packets 0, 1, 2, 3, 0, …, with no interleaving.
  - Exactly one bubble cycle (m_axis_tvalid = 0) between packets.
- Port 2 sends an 8-beat packet; port 1 raises tvalid at beat 3:
  - Port 1 gets no tready until port 2's tlast is accepted.
  - Next grant_idx = 3 if port 3 is requesting, else 0 if port 0 is requesting, else 1.
- Sink holds m_axis_tready = 0 for 5 cycles mid-packet on port 1:
  - m_axis_tvalid stays 1 with stable payload.
  - s_axis_tready stays 4'b0000.
  - Beat count is preserved and no beat is duplicated.
- Single requester, port 3, sends two back-to-back 1-beat packets (tlast = 1): grant_idx = 3 both times, with one IDLE cycle between them.
- rst_n pulsed low during beat 2 of a 4-beat packet:
  - Outputs go to their reset values asynchronously.
  - After release, port 0 is granted first if requesting.
  - busy = 0 until the next arbitration.
